// File: rtl/shift_issue_stage.sv
// Execute-stage sequencer around a combinational shifter: accepts a decoded shift,
// drives registered operands, waits a programmable settle time, then hands the result to writeback.
module shift_issue_stage #(
    parameter int DATA_W        = 32,
    parameter int SHAMT_W       = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [SHAMT_W-1:0] in_imm,
    input  logic [4:0]        in_tag,
    output logic [DATA_W-1:0] shift_A,
    output logic [DATA_W-1:0] shift_shamt,
    output logic              shift_dir,
    output logic              shift_arith,
    input  logic [DATA_W-1:0] shift_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_tag,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b0}});
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [DATA_W-1:0]    a_r;
    logic [SHAMT_W-1:0]   shamt_r;
    logic                 dir_r, arith_r, err_r;
    logic [4:0]           tag_r;
    logic                 in_ready_r, busy_r;
    logic                 out_valid_r, out_zero_r, out_neg_r, out_err_r;
    logic [DATA_W-1:0]    out_result_r;
    logic [4:0]           out_tag_r;

    logic                 accept_s, capture_s, release_s;
    logic [SHAMT_W-1:0]   amt_s;
    logic                 dir_s, arith_s, err_s;
    logic [DATA_W-1:0]    cap_value_s;

    assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
    assign capture_s = (state_r == EXEC) && (cnt_r == CNT_ZERO);
    assign release_s = (state_r == DONE) && out_valid_r && out_ready;

    // Opcode decode: amount source, direction, arithmetic flag, legality
    always_comb begin
        dir_s   = 1'b0;
        arith_s = 1'b0;
        err_s   = 1'b0;
        if (in_op[2]) begin
            amt_s = in_rt[SHAMT_W-1:0];
        end else begin
            amt_s = in_imm;
        end
        case (in_op[1:0])
            2'b00: begin dir_s = 1'b0; arith_s = 1'b0; end
            2'b01: begin dir_s = 1'b1; arith_s = 1'b0; end
            2'b10: begin dir_s = 1'b1; arith_s = 1'b1; end
            default: begin dir_s = 1'b0; arith_s = 1'b0; err_s = 1'b1; end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = EXEC;
                else          state_s = IDLE;
            end
            EXEC: begin
                if (capture_s) state_s = DONE;
                else           state_s = EXEC;
            end
            DONE: begin
                if (release_s) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Illegal ops still traverse EXEC but never expose the shifter output
    always_comb begin
        if (err_r) cap_value_s = {DATA_W{1'b0}};
        else       cap_value_s = shift_result;
    end

    // State register and settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            if (accept_s)
                cnt_r <= CNT_LOAD;
            else if ((state_r == EXEC) && (cnt_r != CNT_ZERO))
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Operand registers feeding the shifter; only written on accept so they stay stable through EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {DATA_W{1'b0}};
            shamt_r <= {SHAMT_W{1'b0}};
            dir_r   <= 1'b0;
            arith_r <= 1'b0;
            err_r   <= 1'b0;
            tag_r   <= 5'd0;
        end else if (accept_s) begin
            a_r     <= in_rs;
            shamt_r <= amt_s;
            dir_r   <= dir_s;
            arith_r <= arith_s;
            err_r   <= err_s;
            tag_r   <= in_tag;
        end
    end

    // Handshake flags: in_ready only in IDLE, busy everywhere else
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else if (accept_s) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
        end else if (release_s) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end
    end

    // Result capture and hold until writeback accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {DATA_W{1'b0}};
            out_tag_r    <= 5'd0;
            out_zero_r   <= 1'b0;
            out_neg_r    <= 1'b0;
            out_err_r    <= 1'b0;
        end else if (capture_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= cap_value_s;
            out_tag_r    <= tag_r;
            out_zero_r   <= is_zero(cap_value_s);
            out_neg_r    <= cap_value_s[DATA_W-1];
            out_err_r    <= err_r;
        end else if (release_s) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign shift_A     = a_r;
    assign shift_shamt = {{(DATA_W-SHAMT_W){1'b0}}, shamt_r};
    assign shift_dir   = dir_r;
    assign shift_arith = arith_r;
    assign out_valid   = out_valid_r;
    assign out_result  = out_result_r;
    assign out_tag     = out_tag_r;
    assign out_zero    = out_zero_r;
    assign out_neg     = out_neg_r;
    assign out_err     = out_err_r;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: a vector table on a SETTLE_CYCLES=1 instance,
// plus hand sequences for backpressure and mid-EXEC reset on a SETTLE_CYCLES=3 instance.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic        in_valid, in_valid3, out_ready, out_ready3;
    logic [2:0]  in_op;
    logic [31:0] in_rs, in_rt;
    logic [4:0]  in_imm, in_tag;

    logic        in_ready, out_valid, out_zero, out_neg, out_err, busy, shift_dir, shift_arith;
    logic [31:0] shift_A, shift_shamt, shift_result, out_result;
    logic [4:0]  out_tag;

    logic        in_ready3, out_valid3, out_zero3, out_neg3, out_err3, busy3, shift_dir3, shift_arith3;
    logic [31:0] shift_A3, shift_shamt3, shift_result3, out_result3;
    logic [4:0]  out_tag3;

    int n_cmp = 0;
    int n_fail = 0;

    shift_issue_stage #(.DATA_W(32), .SHAMT_W(5), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_tag(in_tag),
        .shift_A(shift_A), .shift_shamt(shift_shamt), .shift_dir(shift_dir), .shift_arith(shift_arith),
        .shift_result(shift_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_err(out_err), .busy(busy)
    );

    shift_issue_stage #(.DATA_W(32), .SHAMT_W(5), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_tag(in_tag),
        .shift_A(shift_A3), .shift_shamt(shift_shamt3), .shift_dir(shift_dir3), .shift_arith(shift_arith3),
        .shift_result(shift_result3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_result(out_result3), .out_tag(out_tag3), .out_zero(out_zero3), .out_neg(out_neg3),
        .out_err(out_err3), .busy(busy3)
    );

    // Behavioural combinational shifter attached to each instance
    always_comb begin
        if (!shift_dir)       shift_result = shift_A << shift_shamt;
        else if (shift_arith) shift_result = $unsigned($signed(shift_A) >>> shift_shamt);
        else                  shift_result = shift_A >> shift_shamt;
    end
    always_comb begin
        if (!shift_dir3)       shift_result3 = shift_A3 << shift_shamt3;
        else if (shift_arith3) shift_result3 = $unsigned($signed(shift_A3) >>> shift_shamt3);
        else                   shift_result3 = shift_A3 >> shift_shamt3;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  imm;
        logic [31:0] shamt;
        logic        dir;
        logic        arith;
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'b000, 32'h0000_0001, 32'h0000_0000, 5'd4,  32'd4,  1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0,  32'd4,  1'b1, 1'b1, 32'hF800_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{3'b101, 32'h1234_5678, 32'h0000_0000, 5'd7,  32'd0,  1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3'b001, 32'h0000_0001, 32'h0000_00FF, 5'd1,  32'd1,  1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 5'd2,  32'd2,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{3'b100, 32'h0000_00FF, 32'h0000_0008, 5'd0,  32'd8,  1'b0, 1'b0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b111, 32'h0000_0005, 32'h0000_0003, 5'd0,  32'd3,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0000, 5'd31, 32'd31, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{3'b010, 32'h8000_0001, 32'h0000_0000, 5'd0,  32'd0,  1'b1, 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; rst3 = 1'b1;
        in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b1; out_ready3 = 1'b1;
        in_op = 3'b000; in_rs = 32'h0; in_rt = 32'h0; in_imm = 5'd0; in_tag = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        chk("reset_in_ready",   {31'd0, in_ready},  32'd1);
        chk("reset_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset_busy",       {31'd0, busy},      32'd0);
        chk("reset_out_result", out_result,         32'h0);
        chk("reset_shift_A",    shift_A,            32'h0);
        chk("reset_in_ready3",  {31'd0, in_ready3}, 32'd1);

        // Table: accept, check shifter drive, result one edge later, handshake back to IDLE
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            in_op = vecs[i].op; in_rs = vecs[i].rs; in_rt = vecs[i].rt;
            in_imm = vecs[i].imm; in_tag = 5'(i + 3); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_busy", i),     {31'd0, busy},        32'd1);
            chk($sformatf("v%0d_shift_A", i),  shift_A,              vecs[i].rs);
            chk($sformatf("v%0d_shamt", i),    shift_shamt,          vecs[i].shamt);
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_dir", i),   {31'd0, shift_dir},   {31'd0, vecs[i].dir});
                chk($sformatf("v%0d_arith", i), {31'd0, shift_arith}, {31'd0, vecs[i].arith});
            end
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_result", i),    out_result,         vecs[i].result);
            chk($sformatf("v%0d_tag", i),       {27'd0, out_tag},   32'(i + 3));
            chk($sformatf("v%0d_zero", i),      {31'd0, out_zero},  {31'd0, vecs[i].zero});
            chk($sformatf("v%0d_neg", i),       {31'd0, out_neg},   {31'd0, vecs[i].neg});
            chk($sformatf("v%0d_err", i),       {31'd0, out_err},   {31'd0, vecs[i].err});
            @(negedge clk);
            chk($sformatf("v%0d_released", i),  {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: result held while out_ready low; next instruction waits for handshake
        out_ready = 1'b0;
        in_op = 3'b000; in_rs = 32'h0000_0001; in_imm = 5'd4; in_tag = 5'd21; in_valid = 1'b1;
        @(negedge clk);
        in_op = 3'b010; in_rs = 32'h8000_0000; in_imm = 5'd4; in_tag = 5'd22;
        @(negedge clk);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k),    {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_result", k),   out_result,         32'h0000_0010);
            chk($sformatf("bp%0d_tag", k),      {27'd0, out_tag},   32'd21);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready},  32'd0);
            chk($sformatf("bp%0d_shift_A", k),  shift_A,            32'h0000_0001);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid",    {31'd0, out_valid}, 32'd0);
        chk("bp_released_in_ready", {31'd0, in_ready},  32'd1);
        chk("bp_released_busy",     {31'd0, busy},      32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp2_busy",    {31'd0, busy}, 32'd1);
        chk("bp2_shift_A", shift_A,       32'h8000_0000);
        chk("bp2_shamt",   shift_shamt,   32'd4);
        @(negedge clk);
        chk("bp2_valid",  {31'd0, out_valid}, 32'd1);
        chk("bp2_result", out_result,         32'hF800_0000);
        chk("bp2_tag",    {27'd0, out_tag},   32'd22);
        chk("bp2_neg",    {31'd0, out_neg},   32'd1);
        @(negedge clk);
        chk("bp2_released", {31'd0, out_valid}, 32'd0);

        // SETTLE_CYCLES=3: illegal op leaves out_err set, then reset during EXEC clears it
        in_op = 3'b011; in_rs = 32'hFFFF_FFFF; in_imm = 5'd0; in_tag = 5'd9; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        begin
            int waited = 0;
            while (!out_valid3 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            chk("s3_err_latency", 32'(waited), 32'd3);
        end
        chk("s3_err_flag",   {31'd0, out_err3},  32'd1);
        chk("s3_err_result", out_result3,        32'h0);
        chk("s3_err_zero",   {31'd0, out_zero3}, 32'd1);
        @(negedge clk);
        in_op = 3'b000; in_rs = 32'h0000_0001; in_imm = 5'd31; in_tag = 5'd10; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        chk("s3_rst_in_ready",  {31'd0, in_ready3},  32'd1);
        chk("s3_rst_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("s3_rst_busy",      {31'd0, busy3},      32'd0);
        chk("s3_rst_out_err",   {31'd0, out_err3},   32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("s3_discard%0d", k), {31'd0, out_valid3}, 32'd0);
        end
        in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        chk("s3_exec0_valid", {31'd0, out_valid3}, 32'd0);
        @(negedge clk);
        chk("s3_exec1_valid", {31'd0, out_valid3}, 32'd0);
        @(negedge clk);
        chk("s3_exec2_valid", {31'd0, out_valid3}, 32'd0);
        @(negedge clk);
        chk("s3_done_valid",  {31'd0, out_valid3}, 32'd1);
        chk("s3_done_result", out_result3,         32'h8000_0000);
        chk("s3_done_neg",    {31'd0, out_neg3},   32'd1);
        chk("s3_done_tag",    {27'd0, out_tag3},   32'd10);
        @(negedge clk);
        chk("s3_released", {31'd0, out_valid3}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
